// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: rotating active-low column drive, synchronised and debounced rows,
// ghost rejection, and a small event FIFO presented over valid/ready.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV   = 16,
    parameter int DB_CYCLES  = 1000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col_drv,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [2:0] key_count,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       scan_busy
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(DB_CYCLES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t          state, state_n;
    logic [3:0]      row_m, row_s;
    logic [3:0]      col_n, pat, pat_n;
    logic [1:0]      col_idx, col_idx_n;
    logic [DW-1:0]   dwell, dwell_n;
    logic [BW-1:0]   db_cnt, db_n;
    logic            push;
    logic [3:0]      push_code;

    function automatic logic one_low(input logic [3:0] r);
        one_low = (r == 4'b1110) || (r == 4'b1101) || (r == 4'b1011) || (r == 4'b0111);
    endfunction

    function automatic logic [1:0] row_sel(input logic [3:0] r);
        case (r)
            4'b1101: row_sel = 2'd1;
            4'b1011: row_sel = 2'd2;
            4'b0111: row_sel = 2'd3;
            default: row_sel = 2'd0;
        endcase
    endfunction

    assign push_code = {col_idx, row_sel(pat)};
    assign scan_busy = (state != SCAN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_m   <= 4'hF;
            row_s   <= 4'hF;
            state   <= SCAN;
            col_drv <= 4'b1110;
            col_idx <= 2'd0;
            dwell   <= '0;
            db_cnt  <= '0;
            pat     <= 4'hF;
        end else begin
            row_m   <= row;
            row_s   <= row_m;
            state   <= state_n;
            col_drv <= col_n;
            col_idx <= col_idx_n;
            dwell   <= dwell_n;
            db_cnt  <= db_n;
            pat     <= pat_n;
        end
    end

    always_comb begin
        state_n   = state;
        col_n     = col_drv;
        col_idx_n = col_idx;
        dwell_n   = dwell;
        db_n      = db_cnt;
        pat_n     = pat;
        push      = 1'b0;
        case (state)
            SCAN: begin
                if (dwell == DW'(SCAN_DIV - 1)) begin
                    dwell_n = '0;
                    if (one_low(row_s)) begin
                        pat_n   = row_s;
                        db_n    = '0;
                        state_n = DEBOUNCE;
                    end else begin
                        col_n     = {col_drv[2:0], col_drv[3]};
                        col_idx_n = col_idx + 2'd1;
                    end
                end else begin
                    dwell_n = dwell + DW'(1);
                end
            end
            DEBOUNCE: begin
                if (row_s == pat) begin
                    if (db_cnt == BW'(DB_CYCLES - 1)) begin
                        push    = 1'b1;
                        db_n    = '0;
                        state_n = HELD;
                    end else begin
                        db_n = db_cnt + BW'(1);
                    end
                end else begin
                    // Bounce: re-sample the same column from a fresh dwell
                    state_n = SCAN;
                    dwell_n = '0;
                end
            end
            HELD: begin
                if (row_s == 4'hF) begin
                    if (db_cnt == BW'(DB_CYCLES - 1)) begin
                        state_n   = SCAN;
                        db_n      = '0;
                        dwell_n   = '0;
                        col_n     = {col_drv[2:0], col_drv[3]};
                        col_idx_n = col_idx + 2'd1;
                    end else begin
                        db_n = db_cnt + BW'(1);
                    end
                end else begin
                    db_n = '0;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    logic [3:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          full, pop, push_ok, drop;
    logic [3:0]    head_n;

    assign full     = (cnt == CW'(FIFO_DEPTH));
    assign pop      = key_valid & key_ready;
    assign push_ok  = push & (~full | pop);
    assign drop     = push & full & ~pop;
    assign rd_ptr_n = rd_ptr + PW'(pop);
    assign cnt_n    = cnt + CW'(push_ok) - CW'(pop);
    // The slot becoming head may be the one written this cycle
    assign head_n   = (push_ok && wr_ptr == rd_ptr_n) ? push_code : mem[rd_ptr_n];
    assign key_count = 3'(cnt);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_code;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr    <= rd_ptr_n;
            cnt       <= cnt_n;
            key_valid <= (cnt_n != '0);
            if (cnt_n != '0) key_code <= head_n;
            if (drop) overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end
endmodule
